// File: rtl/sample_stream_generator.sv
// sample_stream_generator
// Captures qualified ADC samples or a generated test pattern, converts each
// unsigned ADC_WIDTH sample to a signed OUT_WIDTH word and buffers it in a
// synchronous FIFO for the FX3 GPIF reader.
//
// Optional feature macro: SAMPLE_DROP_COUNT_EN (adds the dropCount output).
//
// Ports:
//   fx3Clk        sole clock, rising edge
//   nReset        synchronous active-low reset
//   collectData   capture enable (level)
//   sampleValid   adcData qualifier, one cycle per sample
//   adcData       unsigned ADC sample
//   testMode      0=ADC, 1=counter, 2=midscale, 3=alternate 0/all-ones
//   readData      read request from the FX3 side
//   dataOut       signed converted word, registered
//   dataValid     dataOut holds a newly read word this cycle
//   dataAvailable usedWords >= PACKET_WORDS
//   bufferError   sticky overflow / near-full error
//   usedWords     FIFO occupancy
//   dropCount     saturating dropped-sample count (macro only)
//
// state   | meaning
// IDLE    | not capturing; buffered words remain readable
// FLUSH   | one cycle: clear FIFO, pattern state and error
// COLLECT | capturing on sampleValid
module sample_stream_generator #(
    parameter int ADC_WIDTH    = 10,
    parameter int OUT_WIDTH    = 16,
    parameter int FIFO_AW      = 12,
    parameter int PACKET_WORDS = 1024,
    parameter int ERROR_MARGIN = 16
) (
    input  logic                 fx3Clk,
    input  logic                 nReset,
    input  logic                 collectData,
    input  logic                 sampleValid,
    input  logic [ADC_WIDTH-1:0] adcData,
    input  logic [1:0]           testMode,
    input  logic                 readData,
    output logic [OUT_WIDTH-1:0] dataOut,
    output logic                 dataValid,
    output logic                 dataAvailable,
    output logic                 bufferError,
    output logic [FIFO_AW:0]     usedWords
`ifdef SAMPLE_DROP_COUNT_EN
    ,
    output logic [15:0]          dropCount
`endif
);

    localparam int SHIFT = OUT_WIDTH - ADC_WIDTH;
    localparam logic [FIFO_AW:0] DEPTH_W   = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] PKT_W     = (FIFO_AW+1)'(PACKET_WORDS);
    localparam logic [FIFO_AW:0] ERR_LIMIT = DEPTH_W - (FIFO_AW+1)'(ERROR_MARGIN);
    localparam logic [ADC_WIDTH-1:0] MIDSCALE = {1'b1, {(ADC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FLUSH, COLLECT} genState_t;

    genState_t              state;
    logic [OUT_WIDTH-1:0]   mem [0:(1<<FIFO_AW)-1];
    logic [FIFO_AW-1:0]     wrPtr;
    logic [FIFO_AW-1:0]     rdPtr;
    logic [ADC_WIDTH-1:0]   testCounter;
    logic                   toggle;

    logic [ADC_WIDTH-1:0]   sample;
    logic [ADC_WIDTH-1:0]   flipped;
    logic [OUT_WIDTH-1:0]   convWord;
    logic                   capture;
    logic                   rdAcc;
    logic                   wrAcc;
    logic                   drop;
    logic [FIFO_AW:0]       nextCount;

    always_comb begin
        sample = adcData;
        case (testMode)
            2'd1:    sample = testCounter;
            2'd2:    sample = MIDSCALE;
            2'd3:    sample = toggle ? '1 : '0;
            default: sample = adcData;
        endcase
        // Offset binary to two's complement: invert the MSB. Zero-extending and
        // shifting left places the sample at the top of the word, which equals
        // sign-extend-then-shift because the extension bits fall off the top.
        flipped  = sample ^ MIDSCALE;
        convWord = OUT_WIDTH'(flipped) << SHIFT;
    end

    // collectData low in COLLECT stops capture in the same cycle.
    assign capture = (state == COLLECT) && collectData && sampleValid;
    assign rdAcc   = readData && (usedWords != '0) && (state != FLUSH);
    assign wrAcc   = capture && ((usedWords < DEPTH_W) || rdAcc);
    assign drop    = capture && !wrAcc;

    always_comb begin
        nextCount = usedWords;
        case ({wrAcc, rdAcc})
            2'b10:   nextCount = usedWords + (FIFO_AW+1)'(1);
            2'b01:   nextCount = usedWords - (FIFO_AW+1)'(1);
            default: nextCount = usedWords;
        endcase
    end

    // Storage only; no reset so it maps onto block RAM.
    always_ff @(posedge fx3Clk) begin
        if (wrAcc) begin
            mem[wrPtr] <= convWord;
        end
    end

    always_ff @(posedge fx3Clk) begin
        if (!nReset) begin
            state         <= IDLE;
            wrPtr         <= '0;
            rdPtr         <= '0;
            testCounter   <= '0;
            toggle        <= 1'b0;
            dataOut       <= '0;
            dataValid     <= 1'b0;
            dataAvailable <= 1'b0;
            bufferError   <= 1'b0;
            usedWords     <= '0;
`ifdef SAMPLE_DROP_COUNT_EN
            dropCount     <= '0;
`endif
        end else begin
            dataValid <= 1'b0;
            case (state)
                IDLE:    if (collectData) state <= FLUSH;
                FLUSH:   state <= COLLECT;
                COLLECT: if (!collectData) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (state == FLUSH) begin
                wrPtr         <= '0;
                rdPtr         <= '0;
                testCounter   <= '0;
                toggle        <= 1'b0;
                usedWords     <= '0;
                dataAvailable <= 1'b0;
                bufferError   <= 1'b0;
`ifdef SAMPLE_DROP_COUNT_EN
                dropCount     <= '0;
`endif
            end else begin
                if (rdAcc) begin
                    dataOut   <= mem[rdPtr];
                    dataValid <= 1'b1;
                    rdPtr     <= rdPtr + FIFO_AW'(1);
                end
                if (wrAcc) begin
                    wrPtr <= wrPtr + FIFO_AW'(1);
                end
                // Pattern state advances on every capture, dropped or not.
                if (capture && testMode == 2'd1) begin
                    testCounter <= testCounter + ADC_WIDTH'(1);
                end
                if (capture && testMode == 2'd3) begin
                    toggle <= ~toggle;
                end
                usedWords     <= nextCount;
                dataAvailable <= (nextCount >= PKT_W);
                if (drop || ((state == COLLECT) && (nextCount > ERR_LIMIT))) begin
                    bufferError <= 1'b1;
                end
`ifdef SAMPLE_DROP_COUNT_EN
                if (drop && dropCount != 16'hFFFF) begin
                    dropCount <= dropCount + 16'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_sample_stream_generator.sv
module tb_sample_stream_generator;

    logic        fx3Clk = 1'b0;
    logic        nReset = 1'b0;
    logic        collectData = 1'b0;
    logic        sampleValid = 1'b0;
    logic [9:0]  adcData = '0;
    logic [1:0]  testMode = '0;
    logic        readData = 1'b0;
    logic [15:0] dataOut;
    logic        dataValid;
    logic        dataAvailable;
    logic        bufferError;
    logic [12:0] usedWords;
`ifdef SAMPLE_DROP_COUNT_EN
    logic [15:0] dropCount;
`endif

    int checks = 0;
    int failures = 0;

    sample_stream_generator dut (
        .fx3Clk        (fx3Clk),
        .nReset        (nReset),
        .collectData   (collectData),
        .sampleValid   (sampleValid),
        .adcData       (adcData),
        .testMode      (testMode),
        .readData      (readData),
        .dataOut       (dataOut),
        .dataValid     (dataValid),
        .dataAvailable (dataAvailable),
        .bufferError   (bufferError),
        .usedWords     (usedWords)
`ifdef SAMPLE_DROP_COUNT_EN
        ,
        .dropCount     (dropCount)
`endif
    );

    always #5 fx3Clk = ~fx3Clk;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge fx3Clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [9:0]  adc;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{2'd1, 10'h000, 16'h8000};
        vecs[1] = '{2'd1, 10'h000, 16'h8040};
        vecs[2] = '{2'd0, 10'h000, 16'h8000};
        vecs[3] = '{2'd0, 10'h200, 16'h0000};
        vecs[4] = '{2'd0, 10'h3FF, 16'h7FC0};
        vecs[5] = '{2'd2, 10'h123, 16'h0000};
        vecs[6] = '{2'd3, 10'h123, 16'h8000};
        vecs[7] = '{2'd3, 10'h123, 16'h7FC0};
        vecs[8] = '{2'd1, 10'h3FF, 16'h8080};

        // Reset state
        tick();
        tick();
        checkValue("rst_dataOut", dataOut, 0);
        checkValue("rst_dataValid", dataValid, 0);
        checkValue("rst_dataAvailable", dataAvailable, 0);
        checkValue("rst_bufferError", bufferError, 0);
        checkValue("rst_usedWords", usedWords, 0);
        nReset = 1'b1;

        // Counter pattern, 1030 captures with no reads
        testMode = 2'd1;
        collectData = 1'b1;
        tick();
        tick();
        sampleValid = 1'b1;
        for (int i = 1; i <= 1030; i++) begin
            tick();
            if (i == 1023) begin
                checkValue("avail_below", dataAvailable, 0);
                checkValue("used_1023", usedWords, 1023);
            end
            if (i == 1024) checkValue("avail_at_1024", dataAvailable, 1);
        end
        sampleValid = 1'b0;
        tick();
        checkValue("used_1030", usedWords, 1030);

        readData = 1'b1;
        tick();
        checkValue("cnt_rd0", dataOut, 16'h8000);
        checkValue("cnt_rd0_valid", dataValid, 1);
        tick();
        checkValue("cnt_rd1", dataOut, 16'h8040);
        tick();
        checkValue("cnt_rd2", dataOut, 16'h8080);
        readData = 1'b0;
        tick();
        checkValue("rd_idle_valid", dataValid, 0);
        checkValue("rd_idle_hold", dataOut, 16'h8080);
        checkValue("used_1027", usedWords, 1027);

        // Leave COLLECT: words remain readable
        collectData = 1'b0;
        tick();
        checkValue("idle_used", usedWords, 1027);
        readData = 1'b1;
        tick();
        readData = 1'b0;
        checkValue("idle_rd", dataOut, 16'h80C0);
        checkValue("idle_rd_used", usedWords, 1026);

        // Re-enter: FLUSH clears the FIFO and restarts the pattern state
        collectData = 1'b1;
        tick();
        tick();
        checkValue("flush_used", usedWords, 0);
        checkValue("flush_err", bufferError, 0);
        checkValue("flush_avail", dataAvailable, 0);

        foreach (vecs[k]) begin
            testMode = vecs[k].mode;
            adcData = vecs[k].adc;
            sampleValid = 1'b1;
            tick();
        end
        sampleValid = 1'b0;
        tick();
        checkValue("vec_used", usedWords, 9);
        readData = 1'b1;
        foreach (vecs[k]) begin
            tick();
            checkValue($sformatf("vec%0d_data", k), dataOut, vecs[k].exp);
            checkValue($sformatf("vec%0d_valid", k), dataValid, 1);
        end
        // Reads on an empty FIFO are ignored
        for (int i = 0; i < 5; i++) begin
            tick();
            checkValue("empty_valid", dataValid, 0);
            checkValue("empty_hold", dataOut, 16'h8080);
            checkValue("empty_used", usedWords, 0);
        end
        readData = 1'b0;

        // Near-full error threshold and overflow
        testMode = 2'd2;
        sampleValid = 1'b1;
        for (int i = 0; i < 4080; i++) tick();
        sampleValid = 1'b0;
        tick();
        checkValue("used_4080", usedWords, 4080);
        checkValue("err_4080", bufferError, 0);
        sampleValid = 1'b1;
        tick();
        sampleValid = 1'b0;
        tick();
        checkValue("used_4081", usedWords, 4081);
        checkValue("err_4081", bufferError, 1);
        sampleValid = 1'b1;
        for (int i = 0; i < 18; i++) tick();
        sampleValid = 1'b0;
        tick();
        checkValue("full_used", usedWords, 4096);
        checkValue("full_err", bufferError, 1);
        checkValue("full_avail", dataAvailable, 1);
`ifdef SAMPLE_DROP_COUNT_EN
        checkValue("drop_3", dropCount, 3);
`endif
        sampleValid = 1'b1;
        readData = 1'b1;
        tick();
        sampleValid = 1'b0;
        readData = 1'b0;
        checkValue("full_rw_used", usedWords, 4096);
        checkValue("full_rw_valid", dataValid, 1);
        checkValue("full_rw_data", dataOut, 16'h0000);
`ifdef SAMPLE_DROP_COUNT_EN
        checkValue("full_rw_drop", dropCount, 3);
`endif
        collectData = 1'b0;
        tick();
        tick();
        checkValue("idle_err_held", bufferError, 1);
        checkValue("idle_full_used", usedWords, 4096);

        collectData = 1'b1;
        tick();
        tick();
        checkValue("flush2_used", usedWords, 0);
        checkValue("flush2_err", bufferError, 0);
`ifdef SAMPLE_DROP_COUNT_EN
        checkValue("flush2_drop", dropCount, 0);
`endif

        // Reset mid-COLLECT with 100 words buffered
        testMode = 2'd0;
        adcData = 10'h005;
        sampleValid = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        checkValue("used_100", usedWords, 100);
        readData = 1'b1;
        nReset = 1'b0;
        tick();
        checkValue("mid_rst_used", usedWords, 0);
        checkValue("mid_rst_data", dataOut, 0);
        checkValue("mid_rst_valid", dataValid, 0);
        checkValue("mid_rst_avail", dataAvailable, 0);
        checkValue("mid_rst_err", bufferError, 0);
        nReset = 1'b1;
        collectData = 1'b0;
        readData = 1'b0;
        tick();
        tick();
        checkValue("post_rst_used", usedWords, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
